alu_share_arbiter: RTL and testbench

- Shares one ALU (AND/OR/ADD/SUB/SLT datapath) between two requesters: the instruction datapath (port 0) and the branch/compare unit (port 1).
- Round-robin arbitration, valid/ready request handshake, registered operands to the ALU, registered result returned to the granted requester.
- Sits between the control unit and the ALU in the multi-cycle variant of the processor.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_share_arbiter_if.sv | 50 +++++
 rtl/rr_arbiter2.sv | 18 +
 rtl/alu_share_arbiter.sv | 102 ++++++++++
 tb/tb_alu_share_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing logic: op codes, op decode helper and FSM states.
package alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] ALU_AND = 3'b000;
  localparam logic [OP_W-1:0] ALU_OR  = 3'b001;
  localparam logic [OP_W-1:0] ALU_ADD = 3'b010;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b110;
  localparam logic [OP_W-1:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic op_supported(input logic [OP_W-1:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response and ALU-side bundle of the shared ALU arbiter.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OP_W  = alu_pkg::OP_W
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OP_W-1:0]  req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OP_W-1:0]  req1_op;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic             rsp_err;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OP_W-1:0]  alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready, alu_result, alu_zero,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_data, rsp_zero, rsp_err, alu_a, alu_b, alu_op
  );

  // Requester/ALU side
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready, alu_result, alu_zero,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_data, rsp_zero, rsp_err, alu_a, alu_b, alu_op
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin grant; on a tie the port that did not win last time is granted.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters: round-robin accept, registered operands,
// one-cycle execute, registered result held for the owning requester until consumed.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OP_W  = alu_pkg::OP_W
) (
  input logic                clock,
  input logic                reset,
  alu_share_arbiter_if.slave bus
);
  import alu_pkg::*;

  state_t           state;
  logic             last_grant;
  logic             owner;
  logic [1:0]       req_valid;
  logic [1:0]       grant;
  logic             accept;
  logic             rsp_done;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [OP_W-1:0]  sel_op;

  assign req_valid = {bus.req1_valid, bus.req0_valid};

  rr_arbiter2 u_rr (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Grant is only ever nonzero for a valid port, so ready implies a handshake.
  assign bus.req0_ready = (state == IDLE) && grant[0];
  assign bus.req1_ready = (state == IDLE) && grant[1];
  assign accept         = (state == IDLE) && (grant != 2'b00);
  assign rsp_done       = (bus.rsp0_valid && bus.rsp0_ready) ||
                          (bus.rsp1_valid && bus.rsp1_ready);

  always_comb begin
    sel_a  = bus.req0_a;
    sel_b  = bus.req0_b;
    sel_op = bus.req0_op;
    if (grant[1]) begin
      sel_a  = bus.req1_a;
      sel_b  = bus.req1_b;
      sel_op = bus.req1_op;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      owner          <= 1'b0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_op     <= '0;
      bus.rsp_data   <= '0;
      bus.rsp_zero   <= 1'b0;
      bus.rsp_err    <= 1'b0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus.alu_a  <= sel_a;
            bus.alu_b  <= sel_b;
            bus.alu_op <= sel_op;
            owner      <= grant[1];
            last_grant <= grant[1];
            state      <= EXEC;
          end
        end
        EXEC: begin
          // An unsupported op never trusts the ALU output.
          if (op_supported(bus.alu_op)) begin
            bus.rsp_data <= bus.alu_result;
            bus.rsp_zero <= bus.alu_zero;
            bus.rsp_err  <= 1'b0;
          end else begin
            bus.rsp_data <= '0;
            bus.rsp_zero <= 1'b1;
            bus.rsp_err  <= 1'b1;
          end
          bus.rsp0_valid <= ~owner;
          bus.rsp1_valid <= owner;
          state          <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: per-port stimulus queues, a behavioural ALU,
// expected results queued at accept and compared at the response handshake.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    int               dly;
  } stim_t;

  typedef struct {
    logic             port;
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             err;
    int               acc_cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  alu_share_arbiter_if #(.WIDTH(WIDTH), .OP_W(OP_W)) bus ();

  alu_share_arbiter #(.WIDTH(WIDTH), .OP_W(OP_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [WIDTH-1:0] ref_alu(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [2:0] op);
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_SLT: return {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Behavioural ALU; unsupported ops return garbage with a clear zero flag.
  assign bus.alu_result = ref_alu(bus.alu_a, bus.alu_b, bus.alu_op);
  assign bus.alu_zero   = op_supported(bus.alu_op) ? (bus.alu_result == '0) : 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          nvalid = 0;
  int          bp1 = 0;
  stim_t       q0[$];
  stim_t       q1[$];
  stim_t       s0, s1;
  logic        pend0 = 1'b0, pend1 = 1'b0;
  exp_t        sb[$];
  logic        front_seen = 1'b0;
  logic        busy = 1'b0;
  logic        acc0 = 1'b0, acc1 = 1'b0, rv1 = 1'b0;
  logic [33:0] held;
  logic [66:0] last_acc;
  logic        glog_port[$];
  int          glog_cyc[$];
  logic [33:0] rlog[$];

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sample();
    exp_t        e;
    logic        v0, v1, p;
    logic [WIDTH-1:0] r;
    v0 = bus.rsp0_valid;
    v1 = bus.rsp1_valid;
    rv1 = v1;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (reset) begin
      sb.delete();
      busy = 1'b0;
      front_seen = 1'b0;
      return;
    end
    if (busy) begin
      check("ready_busy", 96'({bus.req1_ready, bus.req0_ready}), 96'(0));
      check("alu_hold", 96'({bus.alu_op, bus.alu_a, bus.alu_b}), 96'(last_acc));
    end
    if (v0 || v1) begin
      nvalid++;
      if (sb.size() == 0) begin
        check("rsp_unexpected", 96'({v1, v0}), 96'(0));
      end else begin
        check("rsp_owner", 96'({v1, v0}), sb[0].port ? 96'(2) : 96'(1));
        if (!front_seen) begin
          check("latency", 96'(cyc - sb[0].acc_cyc), 96'(2));
          front_seen = 1'b1;
        end else begin
          check("rsp_hold", 96'({bus.rsp_err, bus.rsp_zero, bus.rsp_data}), 96'(held));
        end
        held = {bus.rsp_err, bus.rsp_zero, bus.rsp_data};
        if ((v0 && bus.rsp0_ready) || (v1 && bus.rsp1_ready)) begin
          e = sb.pop_front();
          check("rsp_data", 96'(bus.rsp_data), 96'(e.data));
          check("rsp_zero", 96'(bus.rsp_zero), 96'(e.zero));
          check("rsp_err", 96'(bus.rsp_err), 96'(e.err));
          rlog.push_back({bus.rsp_err, bus.rsp_zero, bus.rsp_data});
          front_seen = 1'b0;
          busy = 1'b0;
        end
      end
    end
    acc0 = bus.req0_valid && bus.req0_ready;
    acc1 = bus.req1_valid && bus.req1_ready;
    if (acc0 || acc1) begin
      check("one_grant", 96'(acc0 && acc1), 96'(0));
      p = acc1 && !acc0;
      e.port = p;
      if (p) last_acc = {bus.req1_op, bus.req1_a, bus.req1_b};
      else   last_acc = {bus.req0_op, bus.req0_a, bus.req0_b};
      r = ref_alu(last_acc[63:32], last_acc[31:0], last_acc[66:64]);
      e.data    = op_supported(last_acc[66:64]) ? r : '0;
      e.zero    = op_supported(last_acc[66:64]) ? (r == '0) : 1'b1;
      e.err     = !op_supported(last_acc[66:64]);
      e.acc_cyc = cyc;
      sb.push_back(e);
      glog_port.push_back(p);
      glog_cyc.push_back(cyc);
      busy = 1'b1;
    end
  endtask

  task automatic drive_update();
    if (acc0) bus.req0_valid = 1'b0;
    if (acc1) bus.req1_valid = 1'b0;
    if (!bus.req0_valid && !pend0 && q0.size() > 0) begin
      s0 = q0.pop_front();
      pend0 = 1'b1;
    end
    if (pend0) begin
      if (s0.dly > 0) s0.dly = s0.dly - 1;
      else begin
        bus.req0_a = s0.a; bus.req0_b = s0.b; bus.req0_op = s0.op;
        bus.req0_valid = 1'b1;
        pend0 = 1'b0;
      end
    end
    if (!bus.req1_valid && !pend1 && q1.size() > 0) begin
      s1 = q1.pop_front();
      pend1 = 1'b1;
    end
    if (pend1) begin
      if (s1.dly > 0) s1.dly = s1.dly - 1;
      else begin
        bus.req1_a = s1.a; bus.req1_b = s1.b; bus.req1_op = s1.op;
        bus.req1_valid = 1'b1;
        pend1 = 1'b0;
      end
    end
    if (rv1 && bp1 > 0) bp1--;
    bus.rsp1_ready = (bp1 == 0);
  endtask

  task automatic tick();
    @(negedge clock);
    sample();
    @(posedge clock);
    cyc++;
    #1;
    drive_update();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    pend0 = 1'b0;
    pend1 = 1'b0;
    bp1 = 0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    glog_port.delete();
    glog_cyc.delete();
    rlog.delete();
    tick();
    tick();
    check("rst_out", 96'({bus.rsp1_valid, bus.rsp0_valid, bus.rsp_err, bus.rsp_zero, bus.rsp_data}), 96'(0));
    check("rst_alu", 96'({bus.alu_op, bus.alu_a, bus.alu_b}), 96'(0));
    reset = 1'b0;
  endtask

  task automatic run(input int budget);
    int n;
    acc0 = 1'b0;
    acc1 = 1'b0;
    rv1 = 1'b0;
    drive_update();
    n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && !pend0 && !pend1 &&
             !bus.req0_valid && !bus.req1_valid && sb.size() == 0 && !busy)) begin
      if (n >= budget) begin
        check("timeout", 96'(1), 96'(0));
        return;
      end
      tick();
      n++;
    end
  endtask

  initial begin
    int start;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0; bus.req0_valid = 1'b0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0; bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;

    // Reset state, then a single AND on port 0
    do_reset();
    check("rst_ready", 96'({bus.req1_ready, bus.req0_ready}), 96'(0));
    start = cyc;
    q0.push_back('{a: 32'hF0F0_F0F0, b: 32'hFF00_FF00, op: ALU_AND, dly: 0});
    run(40);
    check("t1_n", 96'(rlog.size()), 96'(1));
    check("t1_accept_cyc", 96'(glog_cyc[0] - start), 96'(0));
    check("t1_result", 96'(rlog[0]), 96'({2'b00, 32'hF000_F000}));

    // Both valid through reset: port 0 wins the first tie
    q0.push_back('{a: 32'd1, b: 32'd1, op: ALU_AND, dly: 0});
    q1.push_back('{a: 32'd5, b: 32'd5, op: ALU_SUB, dly: 0});
    do_reset();
    run(40);
    check("t2_order0", 96'(glog_port[0]), 96'(0));
    check("t2_order1", 96'(glog_port[1]), 96'(1));
    check("t2_res0", 96'(rlog[0]), 96'({2'b00, 32'd1}));
    check("t2_res1", 96'(rlog[1]), 96'({2'b01, 32'd0}));

    // Fairness under continuous contention
    do_reset();
    q0.push_back('{a: 32'd100, b: 32'd23, op: ALU_ADD, dly: 0});
    q0.push_back('{a: 32'hFFFF_FFFF, b: 32'd1, op: ALU_SLT, dly: 0});
    q0.push_back('{a: 32'h1234_5678, b: 32'h0F0F_0F0F, op: ALU_AND, dly: 0});
    q1.push_back('{a: 32'd3, b: 32'd10, op: ALU_SUB, dly: 0});
    q1.push_back('{a: 32'd5, b: 32'hFFFF_FFFE, op: ALU_SLT, dly: 0});
    q1.push_back('{a: 32'h8000_0000, b: 32'h0000_0001, op: ALU_OR, dly: 0});
    run(80);
    check("fair_n", 96'(glog_port.size()), 96'(6));
    for (int i = 0; i < 6; i++) check("fair_port", 96'(glog_port[i]), 96'(i % 2));
    for (int i = 1; i < 6; i++) check("fair_gap", 96'(glog_cyc[i] - glog_cyc[i-1]), 96'(3));
    check("fair_add", 96'(rlog[0]), 96'({2'b00, 32'd123}));
    check("fair_sub", 96'(rlog[1]), 96'({2'b00, 32'hFFFF_FFF9}));
    check("fair_slt", 96'(rlog[3]), 96'({2'b01, 32'd0}));

    // Back-pressure on port 1 while port 0 waits
    do_reset();
    bp1 = 5;
    q1.push_back('{a: 32'h0000_000F, b: 32'h0000_00F0, op: ALU_OR, dly: 0});
    q0.push_back('{a: 32'd9, b: 32'd4, op: ALU_ADD, dly: 2});
    run(60);
    check("bp_order0", 96'(glog_port[0]), 96'(1));
    check("bp_order1", 96'(glog_port[1]), 96'(0));
    check("bp_gap", 96'(glog_cyc[1] - glog_cyc[0]), 96'(8));
    check("bp_res", 96'(rlog[0]), 96'({2'b00, 32'h0000_00FF}));

    // Unsupported op code
    do_reset();
    q0.push_back('{a: 32'd5, b: 32'd3, op: 3'b011, dly: 0});
    run(40);
    check("bad_op", 96'(rlog[0]), 96'({2'b11, 32'd0}));

    // Reset while the ALU operation is executing
    do_reset();
    q0.push_back('{a: 32'd7, b: 32'd8, op: ALU_ADD, dly: 0});
    acc0 = 1'b0;
    acc1 = 1'b0;
    drive_update();
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_out", 96'({bus.rsp1_valid, bus.rsp0_valid, bus.rsp_err, bus.rsp_zero, bus.rsp_data}), 96'(0));
    check("mid_rst_alu", 96'({bus.alu_op, bus.alu_a, bus.alu_b}), 96'(0));
    reset = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 6; i++) tick();
    check("mid_rst_quiet", 96'(nvalid), 96'(0));
    rlog.delete();
    q0.push_back('{a: 32'd7, b: 32'd8, op: ALU_ADD, dly: 0});
    run(40);
    check("mid_rst_next", 96'(rlog[0]), 96'({2'b00, 32'd15}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
